// File: rtl/gfx256_pixel_reader_if.sv
// gfx256_pixel_reader_if: pixel request/response and 256-bit line fetch bus
interface gfx256_pixel_reader_if #(parameter int ADDR_W = 32);
  logic [1:0]        color_depth_i;
  logic              pix_req_i;
  logic [ADDR_W-1:0] pix_addr_i;
  logic              pix_ack_o;
  logic [31:0]       color_o;
  logic              busy_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_adr_o;
  logic              mem_ack_i;
  logic [255:0]      mem_dat_i;
  logic              invalidate_i;
  modport slave (
    input  color_depth_i, pix_req_i, pix_addr_i, mem_ack_i, mem_dat_i, invalidate_i,
    output pix_ack_o, color_o, busy_o, mem_req_o, mem_adr_o
  );
  modport master (
    output color_depth_i, pix_req_i, pix_addr_i, mem_ack_i, mem_dat_i, invalidate_i,
    input  pix_ack_o, color_o, busy_o, mem_req_o, mem_adr_o
  );
endinterface

// File: rtl/gfx256_pixel_reader.sv
// gfx256_pixel_reader: single-line cached pixel reader over a 256-bit line bus
module gfx256_pixel_reader #(
  parameter int ADDR_W = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  gfx256_pixel_reader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_t;
  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-6:0]   tag_q, tag_d;
  logic [255:0]        line_q, line_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          depth_q, depth_d;
  logic                inv_q, inv_d;
  logic [31:0]         color_q, color_d;
  logic                hit;
  // Shifting the line right zero-fills, so bytes past the line end read as 0
  function automatic logic [31:0] extract(input logic [255:0] line, input logic [4:0] off,
                                          input logic [1:0] depth);
    logic [255:0] sh;
    sh = line >> {off, 3'b000};
    return depth == 2'd0 ? {24'd0, sh[7:0]}  :
           depth == 2'd1 ? {16'd0, sh[15:0]} :
           depth == 2'd2 ? {8'd0,  sh[23:0]} : sh[31:0];
  endfunction
  // Same-cycle invalidate wins over a tag match, forcing a miss
  assign hit = valid_q && !bus.invalidate_i && tag_q == bus.pix_addr_i[ADDR_W-1:5];
  // Next-state, cache update and result capture
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    line_d  = line_q;
    addr_d  = addr_q;
    depth_d = depth_q;
    inv_d   = inv_q;
    color_d = color_q;
    unique case (state_q)
      IDLE: begin
        if (bus.invalidate_i) valid_d = 1'b0;
        if (bus.pix_req_i) begin
          addr_d  = bus.pix_addr_i;
          depth_d = bus.color_depth_i;
          inv_d   = 1'b0;
          state_d = hit ? DELIVER : FETCH;
          if (hit) color_d = extract(line_q, bus.pix_addr_i[4:0], bus.color_depth_i);
        end
      end
      FETCH: begin
        if (bus.invalidate_i) inv_d = 1'b1;
        if (bus.mem_ack_i) begin
          line_d  = bus.mem_dat_i;
          tag_d   = addr_q[ADDR_W-1:5];
          valid_d = !(inv_q || bus.invalidate_i);
          color_d = extract(bus.mem_dat_i, addr_q[4:0], depth_q);
          state_d = DELIVER;
        end
      end
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and cache registers with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      depth_q <= '0;
      inv_q   <= 1'b0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      depth_q <= depth_d;
      inv_q   <= inv_d;
      color_q <= color_d;
    end
  end
  assign bus.pix_ack_o = state_q == DELIVER;
  assign bus.busy_o    = state_q != IDLE;
  assign bus.mem_req_o = state_q == FETCH;
  assign bus.mem_adr_o = {addr_q[ADDR_W-1:5], 5'b00000};
  assign bus.color_o   = color_q;
endmodule

// File: tb/tb_gfx256_pixel_reader.sv
// tb_gfx256_pixel_reader: vector table plus corner-case sequences with a color scoreboard
module tb_gfx256_pixel_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int ack_cnt = 0;
  logic [31:0] exp_q[$];
  gfx256_pixel_reader_if #(.ADDR_W(32)) bus();
  gfx256_pixel_reader #(.ADDR_W(32)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0]  depth;
    logic [31:0] addr;
    bit          inv;
    bit          miss;
  } vec_t;
  vec_t vecs[8];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 32; k++) l[8*k +: 8] = 8'(k) + (a[15:8] ^ 8'h10);
    return l;
  endfunction
  function automatic logic [31:0] model(input logic [1:0] d, input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  r;
    l = line_of(a);
    r = '0;
    for (int i = 0; i <= int'(d); i++)
      if (int'(a[4:0]) + i < 32) r[8*i +: 8] = l[8*(int'(a[4:0]) + i) +: 8];
    return r;
  endfunction
  always @(negedge clk) begin
    if (rst_n && bus.pix_ack_o) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got color %h want no ack", bus.color_o);
      end else check("color", bus.color_o, exp_q.pop_front());
    end
  end
  task automatic run(input logic [1:0] d, input logic [31:0] a, input bit inv_req, input bit miss,
                     input bit inv_fetch, input bit inv_ack, input bit req_fetch);
    @(posedge clk); #1;
    bus.pix_req_i = 1'b1;
    bus.color_depth_i = d;
    bus.pix_addr_i = a;
    bus.invalidate_i = inv_req;
    exp_q.push_back(model(d, a));
    @(posedge clk); #1;
    bus.pix_req_i = 1'b0;
    bus.invalidate_i = 1'b0;
    check("miss", {31'd0, bus.mem_req_o}, {31'd0, miss});
    if (!miss) begin
      check("hit_ack", {31'd0, bus.pix_ack_o}, 32'd1);
    end else begin
      check("mem_adr", bus.mem_adr_o, {a[31:5], 5'b0});
      bus.invalidate_i = inv_fetch;
      bus.pix_req_i = req_fetch;
      if (req_fetch) begin
        bus.pix_addr_i = a ^ 32'h0000_0100;
        bus.color_depth_i = 2'd0;
      end
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        bus.invalidate_i = 1'b0;
        bus.pix_req_i = 1'b0;
      end
      check("fetch_hold", {bus.mem_req_o, bus.mem_adr_o[30:0]}, {1'b1, a[30:5], 5'b0});
      bus.mem_ack_i = 1'b1;
      bus.mem_dat_i = line_of(a);
      bus.invalidate_i = inv_ack;
      @(posedge clk); #1;
      bus.mem_ack_i = 1'b0;
      bus.invalidate_i = 1'b0;
      check("fill_ack", {30'd0, bus.pix_ack_o, bus.mem_req_o}, 32'd2);
    end
    @(posedge clk); #1;
    check("idle", {31'd0, bus.busy_o}, 32'd0);
  endtask
  initial begin
    int acks;
    logic [31:0] held;
    bus.pix_req_i = 1'b0;
    bus.color_depth_i = 2'd0;
    bus.pix_addr_i = '0;
    bus.invalidate_i = 1'b0;
    bus.mem_ack_i = 1'b0;
    bus.mem_dat_i = '0;
    vecs[0] = '{2'd3, 32'h1004, 1'b0, 1'b1};
    vecs[1] = '{2'd0, 32'h101F, 1'b0, 1'b0};
    vecs[2] = '{2'd2, 32'h101E, 1'b0, 1'b0};
    vecs[3] = '{2'd1, 32'h1000, 1'b0, 1'b0};
    vecs[4] = '{2'd3, 32'h1008, 1'b1, 1'b1};
    vecs[5] = '{2'd3, 32'h101C, 1'b0, 1'b0};
    vecs[6] = '{2'd3, 32'h2043, 1'b0, 1'b1};
    vecs[7] = '{2'd0, 32'h1001, 1'b0, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", {bus.pix_ack_o, bus.busy_o, bus.mem_req_o, 29'd0}, 32'd0);
    check("rst_color", bus.color_o, 32'd0);
    check("rst_adr", bus.mem_adr_o, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++)
      run(vecs[i].depth, vecs[i].addr, vecs[i].inv, vecs[i].miss, 1'b0, 1'b0, 1'b0);
    held = model(2'd0, 32'h1001);
    repeat (2) @(posedge clk);
    #1;
    check("color_hold", bus.color_o, held);
    run(2'd1, 32'h1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(2'd3, 32'h3004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run(2'd3, 32'h3008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(2'd2, 32'h300C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(2'd1, 32'h3400, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run(2'd1, 32'h3402, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.pix_req_i = 1'b1;
    bus.color_depth_i = 2'd3;
    bus.pix_addr_i = 32'h4004;
    @(posedge clk); #1;
    bus.pix_req_i = 1'b0;
    check("pre_rst_fetch", {31'd0, bus.mem_req_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid", {bus.mem_req_o, bus.busy_o, bus.pix_ack_o, 29'd0}, 32'd0);
    check("rst_mid_adr", bus.mem_adr_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    acks = ack_cnt;
    bus.mem_ack_i = 1'b1;
    bus.mem_dat_i = line_of(32'h4000);
    @(posedge clk); #1;
    bus.mem_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stray_ack", ack_cnt, acks);
    run(2'd3, 32'h2000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    acks = ack_cnt;
    run(2'd3, 32'h5014, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("one_ack", ack_cnt - acks, 32'd1);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gfx256_pixel_reader.md
GFX256_PIXEL_READER -- requirements
Module: gfx256_pixel_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, giving the byte-address width of pixel and memory addresses.
REQ-002 SHALL have port clk_i, input, 1: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port color_depth_i, input, 2: pixel width; 0=8, 1=16, 2=24, 3=32 bits.
REQ-005 SHALL have port pix_req_i, input, 1: single-cycle pixel read request pulse.
REQ-006 SHALL have port pix_addr_i, input, ADDR_W: byte address of the pixel's least significant byte.
REQ-007 SHALL have port pix_ack_o, output, 1: one-cycle pulse marking color_o valid.
REQ-008 SHALL have port color_o, output, 32: extracted pixel, zero-extended.
REQ-009 SHALL have port busy_o, output, 1: high whenever the state is not IDLE.
REQ-010 SHALL have port mem_req_o, output, 1: 256-bit line read request, level, held until acknowledged.
REQ-011 SHALL have port mem_adr_o, output, ADDR_W: line address, with bits [4:0] always zero.
REQ-012 SHALL have port mem_ack_i, input, 1: single-cycle pulse marking mem_dat_i valid.
REQ-013 SHALL have port mem_dat_i, input, 256: line data; byte k occupies bits [8k+7:8k].
REQ-014 SHALL have port invalidate_i, input, 1: discard the cached line.

Function
REQ-015 SHALL hold one cached line: a 256-bit data register, a tag (pixel address bits [ADDR_W-1:5]) and a valid bit.
REQ-016 SHALL implement three states: IDLE, FETCH and DELIVER, all registered.
REQ-017 In IDLE, pix_req_i=1 SHALL latch pix_addr_i and color_depth_i; pix_req_i is ignored in every other state.
REQ-018 On acceptance with valid=1 and a matching tag (hit), SHALL go to DELIVER.
REQ-019 On a hit, pix_ack_o SHALL be high in the cycle immediately after acceptance, giving a latency of 1.
REQ-020 On acceptance otherwise (miss), SHALL go to FETCH.
REQ-021 In FETCH, mem_req_o SHALL be 1 and mem_adr_o SHALL be {latched addr[ADDR_W-1:5], 5'b0}, both stable until mem_ack_i.
REQ-022 On mem_ack_i in FETCH, SHALL capture mem_dat_i, load the tag, set valid and go to DELIVER.
REQ-023 The FETCH-to-DELIVER transition SHALL cause mem_req_o to drop in the cycle after mem_ack_i.
REQ-024 DELIVER SHALL last exactly one cycle with pix_ack_o=1, then return to IDLE.
REQ-025 A new request SHALL be accepted no earlier than the cycle after DELIVER.
REQ-026 Extraction SHALL compute color_o = (line >> {addr[4:0],3'b000}) masked to 8/16/24/32 bits per the latched depth.
REQ-027 Line bytes beyond byte 31 SHALL read as zero; there is no access spanning two lines.
REQ-028 color_o SHALL be registered, be valid only while pix_ack_o=1, and hold its last value otherwise.
REQ-029 In IDLE, invalidate_i SHALL clear valid.
REQ-030 In IDLE, invalidate_i together with pix_req_i SHALL clear valid first, so the request is a miss.
REQ-031 In FETCH, invalidate_i SHALL cause the fetched line to be delivered but left invalid; this applies even if invalidate_i coincides with mem_ack_i.
REQ-032 mem_ack_i SHALL be ignored outside FETCH.
REQ-033 A change of color_depth_i after acceptance SHALL not affect the pending result.

Reset
REQ-034 rst_ni=0 SHALL immediately (asynchronously) force state=IDLE, valid=0, pix_ack_o=0, mem_req_o=0, busy_o=0, color_o=0, mem_adr_o=0, with the tag and line data set to 0.
REQ-035 Reset asserted during FETCH SHALL abandon the fetch; a late mem_ack_i after release SHALL be ignored.
REQ-036 After rst_ni rises, the first pix_req_i SHALL be accepted on the first rising clock edge.

Verification
REQ-037 Cold miss: depth=3, addr=0x1004, mem_ack_i 3 cycles after mem_req_o with byte k = k -> mem_adr_o=0x1000; color_o=0x07060504; pix_ack_o one cycle after ack.
REQ-038 Hit: after REQ-037, depth=0, addr=0x101F -> no mem_req_o; pix_ack_o next cycle with color_o=0x0000001F.
REQ-039 Line-end truncation: depth=2, addr=0x101E -> color_o=0x00001F1E.
REQ-040 Invalidate: invalidate_i and pix_req_i (addr=0x1008) in the same IDLE cycle -> miss, mem_req_o to 0x1000.
REQ-041 Invalidate in FETCH: the following request to the same line is a miss.
REQ-042 Reset mid-FETCH: rst_ni low for 1 cycle -> mem_req_o=0 at once; a stray mem_ack_i gives no pix_ack_o; the next request (addr=0x2000) fetches 0x2000.
REQ-043 Busy ignore: a second pix_req_i during FETCH -> exactly one pix_ack_o, for the first address.
